// File: rtl/byteswap_endian_converter_pkg.sv
// Shared definitions for the byteswap endianness converter: lane-size mode
// encodings and the constant functions that describe the byte permutation.
package byteswap_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_SWAP16 = 2'd1,
        MODE_SWAP32 = 2'd2,
        MODE_SWAP64 = 2'd3
    } mode_e;

    function automatic int unsigned lane_bytes(input logic [1:0] mode);
        case (mode)
            MODE_SWAP16: return 2;
            MODE_SWAP32: return 4;
            MODE_SWAP64: return 8;
            default:     return 1;
        endcase
    endfunction

    // Source byte index feeding output byte k when lanes are l bytes wide.
    function automatic int unsigned swap_src(input int unsigned k, input int unsigned l);
        return (k - (k % l)) + (l - 1 - (k % l));
    endfunction

endpackage

// File: rtl/byteswap_endian_converter_lane_permute.sv
// Combinational byte/keep permutation: all four fixed lane reversals are wired
// in parallel and the requested one is selected by mode.
module byteswap_lane_permute
    import byteswap_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512
) (
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   data,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] keep,
    input  logic [1:0]                      mode,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   perm_data,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] perm_keep
);

    localparam int unsigned NB = C_AXIS_TDATA_WIDTH / 8;

    logic [3:0][C_AXIS_TDATA_WIDTH-1:0] cand_data;
    logic [3:0][NB-1:0]                 cand_keep;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        for (genvar k = 0; k < NB; k++) begin : g_byte
            localparam int unsigned SRC = swap_src(k, lane_bytes(2'(m)));
            assign cand_data[m][k*8 +: 8] = data[SRC*8 +: 8];
            assign cand_keep[m][k]        = keep[SRC];
        end
    end

    always_comb begin
        perm_data = cand_data[mode];
        perm_keep = cand_keep[mode];
    end

endmodule

// File: rtl/byteswap_endian_converter.sv
// AXI4-Stream endianness converter: two-stage skid-free pipeline (D1 capture,
// D2 swapped output) with per-packet lane-size latching and handshake stats.
module byteswap_endian_converter
    import byteswap_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_STAT_WIDTH       = 32
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic [1:0]                      cfg_mode,
    input  logic                            stat_clear,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_STAT_WIDTH-1:0]         stat_pkt_count,
    output logic [C_STAT_WIDTH-1:0]         stat_beat_count,
    output logic                            busy
);

    localparam int unsigned KW = C_AXIS_TDATA_WIDTH / 8;

    logic                          d1_valid;
    logic [C_AXIS_TDATA_WIDTH-1:0] d1_data;
    logic [KW-1:0]                 d1_keep;
    logic                          d1_last;
    mode_e                         d1_mode;

    logic                          d2_valid;
    logic [C_AXIS_TDATA_WIDTH-1:0] d2_data;
    logic [KW-1:0]                 d2_keep;
    logic                          d2_last;

    logic                          in_pkt;
    mode_e                         mode_q;
    mode_e                         cur_mode;

    logic                          d1_ready;
    logic                          d2_ready;
    logic                          in_accept;
    logic                          out_accept;

    logic [C_AXIS_TDATA_WIDTH-1:0] perm_data;
    logic [KW-1:0]                 perm_keep;

    logic [C_STAT_WIDTH-1:0]       pkt_cnt;
    logic [C_STAT_WIDTH-1:0]       beat_cnt;

    assign d2_ready      = m_axis_tready | ~d2_valid;
    assign d1_ready      = d2_ready | ~d1_valid;
    assign s_axis_tready = d1_ready;
    assign in_accept     = s_axis_tvalid & d1_ready;
    assign out_accept    = d2_valid & m_axis_tready;

    // First beat of a packet takes cfg_mode live; the rest reuse the latched copy.
    assign cur_mode = in_pkt ? mode_q : mode_e'(cfg_mode);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            in_pkt <= 1'b0;
            mode_q <= MODE_PASS;
        end else if (in_accept) begin
            if (!in_pkt) begin
                mode_q <= mode_e'(cfg_mode);
            end
            in_pkt <= ~s_axis_tlast;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            d1_valid <= 1'b0;
            d1_data  <= '0;
            d1_keep  <= '0;
            d1_last  <= 1'b0;
            d1_mode  <= MODE_PASS;
        end else if (d1_ready) begin
            d1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                d1_data <= s_axis_tdata;
                d1_keep <= s_axis_tkeep;
                d1_last <= s_axis_tlast;
                d1_mode <= cur_mode;
            end
        end
    end

    byteswap_lane_permute #(
        .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH)
    ) u_permute (
        .data      (d1_data),
        .keep      (d1_keep),
        .mode      (d1_mode),
        .perm_data (perm_data),
        .perm_keep (perm_keep)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            d2_valid <= 1'b0;
            d2_data  <= '0;
            d2_keep  <= '0;
            d2_last  <= 1'b0;
        end else if (d2_ready) begin
            d2_valid <= d1_valid;
            if (d1_valid) begin
                d2_data <= perm_data;
                d2_keep <= perm_keep;
                d2_last <= d1_last;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (stat_clear) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (out_accept) begin
            beat_cnt <= beat_cnt + C_STAT_WIDTH'(1);
            if (d2_last) begin
                pkt_cnt <= pkt_cnt + C_STAT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tvalid   = d2_valid;
    assign m_axis_tdata    = d2_data;
    assign m_axis_tkeep    = d2_keep;
    assign m_axis_tlast    = d2_last;
    assign stat_pkt_count  = pkt_cnt;
    assign stat_beat_count = beat_cnt;
    assign busy            = in_pkt | d1_valid | d2_valid;

endmodule

// File: tb/tb_byteswap_endian_converter.sv
// Directed bench for byteswap_endian_converter at 64-bit data and 4-bit stats;
// a forked monitor scores every m_axis handshake against an expected queue.
module tb_byteswap_endian_converter;

    localparam int unsigned W  = 64;
    localparam int unsigned KW = 8;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cfg_mode;
    logic          stat_clear;
    logic          s_tvalid;
    logic          s_tready;
    logic [W-1:0]  s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [W-1:0]  m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [SW-1:0] pkt_cnt;
    logic [SW-1:0] beat_cnt;
    logic          busy;

    logic          rand_rdy;
    logic          man_rdy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t expq[$];

    always #5 clk = ~clk;

    byteswap_endian_converter #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_STAT_WIDTH       (SW)
    ) dut (
        .s_axis_aclk     (clk),
        .s_axis_aresetn  (rst_n),
        .cfg_mode        (cfg_mode),
        .stat_clear      (stat_clear),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tlast    (s_tlast),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tlast    (m_tlast),
        .stat_pkt_count  (pkt_cnt),
        .stat_beat_count (beat_cnt),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] model(input logic [63:0] d, input logic [7:0] k,
                                          input logic [1:0] m);
        int unsigned ln;
        int unsigned s;
        logic [63:0] od;
        logic [7:0]  ok;
        ln = (m == 2'd0) ? 1 : (1 << m);
        od = '0;
        ok = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            s = (b / ln) * ln + (ln - 1 - (b % ln));
            od[b*8 +: 8] = d[s*8 +: 8];
            ok[b]        = k[s];
        end
        return {ok, od};
    endfunction

    task automatic expect_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t e;
        e.d = d;
        e.k = k;
        e.l = l;
        expq.push_back(e);
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [1:0] mode);
        logic acc;
        int unsigned n;
        n        = 0;
        acc      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        cfg_mode = mode;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        s_tvalid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic idle(input int unsigned n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n        = 0;
        s_tvalid = 1'b0;
        while ((expq.size() != 0 || m_tvalid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, expq.size(), 0);
    endtask

    task automatic mon();
        beat_t e;
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                chk("extra_output_beat", expq.size(), 1);
            end else begin
                e = expq.pop_front();
                chk("out_data", m_tdata, e.d);
                chk("out_keep", m_tkeep, e.k);
                chk("out_last", m_tlast, e.l);
            end
        end
        if (!s_tready) begin
            chk("s_ready_low_only_when_full", m_tvalid && !m_tready, 1);
        end
    endtask

    initial begin : main
        int unsigned sent;
        int unsigned npk;
        int unsigned len;
        logic [1:0]  pmode;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [71:0] r;

        rst_n      = 1'b0;
        cfg_mode   = 2'd0;
        stat_clear = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        man_rdy    = 1'b1;
        rand_rdy   = 1'b0;

        fork
            forever begin
                @(posedge clk);
                #2;
                m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : man_rdy;
            end
            forever begin
                @(negedge clk);
                if (rst_n) mon();
            end
        join_none

        #3;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_tready", s_tready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Mode 2 single beat, two-stage latency.
        expect_beat(64'h3322110077665544, 8'hFF, 1'b1);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd2);
        @(negedge clk);
        chk("lat_stage1_not_valid", m_tvalid, 0);
        @(negedge clk);
        chk("lat_stage2_valid", m_tvalid, 1);
        chk("lat_swap32_data", m_tdata, 64'h3322110077665544);
        drain("drain_swap32");
        chk("pkt_cnt_after_1", pkt_cnt, 1);
        chk("beat_cnt_after_1", beat_cnt, 1);

        // Modes 0/1/3 back to back, plus sparse keep under 64-bit swap.
        expect_beat(64'h0011223344556677, 8'hFF, 1'b1);
        expect_beat(64'h1100332255447766, 8'hFF, 1'b1);
        expect_beat(64'h7766554433221100, 8'hFF, 1'b1);
        expect_beat(64'h7766554433221100, 8'hF0, 1'b1);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd0);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd1);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd3);
        send(64'h0011223344556677, 8'h0F, 1'b1, 2'd3);
        drain("drain_modes");

        // Mode change 3->1 mid packet is ignored until the next packet.
        expect_beat(64'h7766554433221100, 8'hFF, 1'b0);
        expect_beat(64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0);
        expect_beat(64'h0807060504030201, 8'hC0, 1'b0);
        expect_beat(64'h8090A0B0C0D0E0F0, 8'hFF, 1'b1);
        expect_beat(64'h1100332255447766, 8'hFF, 1'b1);
        send(64'h0011223344556677, 8'hFF, 1'b0, 2'd3);
        chk("busy_mid_packet", busy, 1);
        send(64'h8899AABBCCDDEEFF, 8'hFF, 1'b0, 2'd1);
        send(64'h0102030405060708, 8'h03, 1'b0, 2'd1);
        send(64'hF0E0D0C0B0A09080, 8'hFF, 1'b1, 2'd1);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd1);
        drain("drain_mode_latch");
        chk("busy_idle", busy, 0);

        // 1000 beats, random packets/modes/keep, 50% output backpressure.
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        chk("stat_clear_beats", beat_cnt, 0);
        rand_rdy = 1'b1;
        sent     = 0;
        npk      = 0;
        while (sent < 1000) begin
            len   = $urandom_range(1, 8);
            pmode = 2'($urandom_range(0, 3));
            if (len > 1000 - sent) len = 1000 - sent;
            npk++;
            for (int unsigned b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                k = 8'($urandom);
                l = (b == len - 1);
                r = model(d, k, pmode);
                expect_beat(r[63:0], r[71:64], l);
                send(d, k, l, (b == 0) ? pmode : 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            sent += len;
        end
        drain("drain_random");
        rand_rdy = 1'b0;
        idle(1);
        chk("random_beat_cnt", beat_cnt, 64'(1000 % 16));
        chk("random_pkt_cnt", pkt_cnt, 64'(npk % 16));

        // Reset with two beats in flight and an open packet latched in mode 3.
        man_rdy = 1'b0;
        idle(1);
        send(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 2'd3);
        send(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 2'd3);
        @(negedge clk);
        chk("full_pipe_s_tready", s_tready, 0);
        chk("full_pipe_m_tvalid", m_tvalid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_beat_cnt", beat_cnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_tready", s_tready, 1);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        man_rdy = 1'b1;
        idle(1);
        expect_beat(64'h1100332255447766, 8'hFF, 1'b1);
        send(64'h0011223344556677, 8'hFF, 1'b1, 2'd1);
        drain("drain_post_reset");
        chk("post_reset_pkt_cnt", pkt_cnt, 1);

        // stat_clear coincident with a tlast output handshake.
        man_rdy = 1'b0;
        idle(1);
        expect_beat(64'h0000_0000_0000_00A5, 8'hFF, 1'b1);
        send(64'h0000_0000_0000_00A5, 8'hFF, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        chk("hold_before_clear_valid", m_tvalid, 1);
        stat_clear = 1'b1;
        man_rdy    = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        chk("clear_vs_inc_pkt", pkt_cnt, 0);
        chk("clear_vs_inc_beat", beat_cnt, 0);
        drain("drain_clear");

        // 17 packets on 4-bit counters wrap to 1.
        for (int unsigned i = 0; i < 17; i++) begin
            expect_beat(64'(i), 8'hFF, 1'b1);
            send(64'(i), 8'hFF, 1'b1, 2'd0);
        end
        drain("drain_wrap");
        chk("wrap_pkt_cnt", pkt_cnt, 1);
        chk("wrap_beat_cnt", beat_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byteswap_endian_converter.md
# byteswap_endian_converter

Runtime-configurable AXI4-Stream endianness converter; successor to the fixed 32-bit byte swapper. Byte order is reversed inside lanes of 2, 4 or 8 bytes, or data passes through unchanged. The lane size is chosen per packet from a sideband mode input, and tkeep is permuted with the data. Sits between the read mover and the compute kernel in the byteswap datapath, with a packet/beat statistics port for the host.

## Interface

Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width in bits; multiple of 64, minimum 64.
- C_STAT_WIDTH, 32, width of statistics counters.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- cfg_mode  in  2  lane-size select: 0 passthrough, 1 swap in 16-bit lanes, 2 in 32-bit lanes, 3 in 64-bit lanes.
- stat_clear  in  1  synchronous clear of statistics counters.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accept.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input data.
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  input byte enables.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output beat accept.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  swapped data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  swapped byte enables.
- m_axis_tlast  out  1  output end of packet.
- stat_pkt_count  out  C_STAT_WIDTH  packets completed on m_axis.
- stat_beat_count  out  C_STAT_WIDTH  beats completed on m_axis.
- busy  out  1  high while a packet is open on the input or any pipeline stage is valid.

## Operation

- Two register stages, D1 and D2. D1 captures the input beat and the mode in effect for it. D2 holds the swapped data and keep plus the forwarded tlast.
- Ready chain: d2_ready = m_axis_tready | ~d2_valid; d1_ready = d2_ready | ~d1_valid; s_axis_tready = d1_ready. Full throughput of one beat per cycle with no bubbles.
- Mode latching uses an in_pkt flag, set on an accepted non-last beat and cleared on an accepted tlast beat.
  - The first beat of a packet (in_pkt=0) uses cfg_mode directly and also loads mode_q.
  - Later beats use mode_q.
  - A cfg_mode change mid-packet has no effect until the next packet.
- Swap rule: for lane size L bytes (L=1 for passthrough), output byte k = input byte (k − k mod L) + (L−1 − k mod L). The same permutation applies to tkeep bits.
- tkeep content is not validated; sparse or null keep is swapped as given.
- Statistics:
  - stat_beat_count increments on each m_axis handshake.
  - stat_pkt_count increments on each handshake with tlast=1.
  - Both wrap modulo 2^C_STAT_WIDTH.
  - stat_clear zeros both, overriding an increment in the same cycle.

## Timing

- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, stat counters=0, busy=0, in_pkt=0, mode_q=0. s_axis_tready=1 after reset, since both stages are empty.
- Latency: a beat accepted at edge N appears on m_axis from edge N+2 when m_axis_tready is held high.
- Backpressure:
  - m_axis_tready low with D2 valid holds D2 stable (AXIS rule: data must not change while valid and not ready).
  - If D1 is also valid, s_axis_tready drops in the same cycle (combinational path).
  - At most 2 beats are in flight.
- A simultaneous output handshake and new input accept advances both stages in the same edge.
- Mid-operation reset: all in-flight beats are discarded, tvalid deasserts asynchronously, and the mode latch returns to 0.

## Structure

- Package byteswap_pkg holds:
  - mode encodings: MODE_PASS, MODE_SWAP16, MODE_SWAP32, MODE_SWAP64;
  - a localparam function lane_bytes(mode).
- Sub-module byteswap_lane_permute is purely combinational. Inputs are data, keep and mode; outputs are permuted data and keep, built from generate loops over the four fixed permutations plus a mux. It is instantiated once, between D1 and D2.

## Test plan

- Mode 2, width 64: single beat tdata=0x0011223344556677, tkeep=0xFF, tlast=1 -> m_axis_tdata=0x3322110077665544 after 2 cycles; stat_pkt_count=1.
- Modes 0/1/3 on the same beat: expect 0x0011223344556677 / 0x1100332255447766 / 0x7766554433221100; tkeep=0x0F with mode 3 -> 0xF0.
- cfg_mode switched 3->1 on beat 2 of a 4-beat packet -> all 4 beats use mode 3; next packet uses mode 1.
- Random m_axis_tready (50%) over 1000 beats -> output sequence matches model, no drops or duplicates; s_axis_tready low only with both stages full.
- Reset asserted with 2 beats in flight -> m_axis_tvalid=0 immediately; counters=0; first post-reset packet uses the current cfg_mode.
- stat_clear coincident with an output tlast handshake -> counters read 0 next cycle; C_STAT_WIDTH=4 with 17 packets -> stat_pkt_count=1.
